// File: rtl/fix_rx_pkg.sv
// Shared state encoding, error codes and ASCII constants for the FIX receive framing checker.
// The CSUM state only exists when FIX_RX_CHECKSUM_EN is defined.
package fix_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StBegin,
        StTag9,
        StLen,
        StBody,
        StTrailer
`ifdef FIX_RX_CHECKSUM_EN
        , StCsum
`endif
    } rx_state_e;

    localparam logic [2:0] ErrNone     = 3'd0;
    localparam logic [2:0] ErrNoTag9   = 3'd1;
    localparam logic [2:0] ErrBadDigit = 3'd2;
    localparam logic [2:0] ErrTrailer  = 3'd3;
    localparam logic [2:0] ErrCsum     = 3'd4;
    localparam logic [2:0] ErrOverflow = 3'd5;

    localparam logic [7:0] AsciiSoh  = 8'h01;
    localparam logic [7:0] AsciiEq   = 8'h3d;
    localparam logic [7:0] AsciiZero = 8'h30;
    localparam logic [7:0] AsciiOne  = 8'h31;
    localparam logic [7:0] AsciiNine = 8'h39;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= AsciiZero) && (b <= AsciiNine);
    endfunction

endpackage

// File: rtl/ascii_dec_accum.sv
// ASCII decimal accumulator: folds one digit per enabled cycle into acc = acc*10 + d and
// reports, for the byte currently presented, whether it is a non-digit or would overflow.
module ascii_dec_accum
    import fix_rx_pkg::*;
#(
    parameter int unsigned ACC_WIDTH  = 16,
    parameter int unsigned MAX_DIGITS = 5,
    localparam int unsigned CNT_WIDTH = $clog2(MAX_DIGITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 digit_valid_i,
    input  logic [7:0]           byte_i,
    output logic [ACC_WIDTH-1:0] acc_o,
    output logic [CNT_WIDTH-1:0] ndigits_o,
    output logic                 non_digit_o,
    output logic                 ovf_o
);

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [ACC_WIDTH+3:0] acc_ext, sum;
    logic [3:0]           digit;

    always_comb begin
        non_digit_o = !is_digit(byte_i);
        // '0'..'9' are 8'h30..8'h39, so the low nibble is the digit value
        digit       = byte_i[3:0];
        acc_ext     = {4'b0000, acc_q};
        sum         = (acc_ext << 3) + (acc_ext << 1) + {{ACC_WIDTH{1'b0}}, digit};
        ovf_o       = |sum[ACC_WIDTH+3:ACC_WIDTH];

        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (digit_valid_i && !non_digit_o && !ovf_o &&
                     (cnt_q != CNT_WIDTH'(MAX_DIGITS))) begin
            acc_d = sum[ACC_WIDTH-1:0];
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc_o     = acc_q;
    assign ndigits_o = cnt_q;

endmodule

// File: rtl/fix_bodylength_rx.sv
// Receive-side FIX framing checker: parses 9=<len>, counts body bytes and checks that 10= starts
// exactly where the declared body ends. Define FIX_RX_CHECKSUM_EN to also verify the checksum.
module fix_bodylength_rx
    import fix_rx_pkg::*;
#(
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned MAX_DIGITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           byte_i,
    input  logic                 byte_valid_i,
    input  logic                 sof_i,
    output logic [LEN_WIDTH-1:0] body_len_o,
    output logic [LEN_WIDTH-1:0] body_cnt_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [2:0]           err_code_o,
    output logic [7:0]           checksum_o
);

    localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);

    rx_state_e            state_q, state_d;
    logic [1:0]           pos_q, pos_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0]           code_q, code_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic [7:0]           trl_exp;

    logic                 len_clr, len_dv, len_non_digit, len_ovf;
    logic [LEN_WIDTH-1:0] len_acc;
    logic [CntW-1:0]      len_nd;

    ascii_dec_accum #(
        .ACC_WIDTH  (LEN_WIDTH),
        .MAX_DIGITS (MAX_DIGITS)
    ) u_len_accum (
        .clk           (clk),
        .rst           (rst),
        .clr_i         (len_clr),
        .digit_valid_i (len_dv),
        .byte_i        (byte_i),
        .acc_o         (len_acc),
        .ndigits_o     (len_nd),
        .non_digit_o   (len_non_digit),
        .ovf_o         (len_ovf)
    );

`ifdef FIX_RX_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
    logic       cs_clr, cs_dv, cs_non_digit, cs_ovf;
    logic [9:0] cs_acc;
    logic [1:0] cs_nd;

    ascii_dec_accum #(
        .ACC_WIDTH  (10),
        .MAX_DIGITS (3)
    ) u_cs_accum (
        .clk           (clk),
        .rst           (rst),
        .clr_i         (cs_clr),
        .digit_valid_i (cs_dv),
        .byte_i        (byte_i),
        .acc_o         (cs_acc),
        .ndigits_o     (cs_nd),
        .non_digit_o   (cs_non_digit),
        .ovf_o         (cs_ovf)
    );
`endif

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        len_clr = 1'b0;
        len_dv  = 1'b0;
        cnt_inc = cnt_q + LEN_WIDTH'(1);
        trl_exp = (pos_q == 2'd0) ? AsciiOne : (pos_q == 2'd1) ? AsciiZero : AsciiEq;
`ifdef FIX_RX_CHECKSUM_EN
        sum_d  = sum_q;
        cs_clr = 1'b0;
        cs_dv  = 1'b0;
`endif

        if (byte_valid_i && sof_i) begin
            // A start-of-frame byte always wins: any frame in flight is dropped without a pulse.
            state_d = StBegin;
            pos_d   = 2'd0;
            len_d   = '0;
            cnt_d   = '0;
            code_d  = ErrNone;
            len_clr = 1'b1;
`ifdef FIX_RX_CHECKSUM_EN
            sum_d  = byte_i;
            cs_clr = 1'b1;
`endif
        end else if (byte_valid_i) begin
`ifdef FIX_RX_CHECKSUM_EN
            if (state_q inside {StBegin, StTag9, StLen, StBody}) begin
                sum_d = sum_q + byte_i;
            end
`endif
            unique case (state_q)
                StIdle: begin
                end
                StBegin: begin
                    if (byte_i == AsciiSoh) begin
                        state_d = StTag9;
                        pos_d   = 2'd0;
                    end
                end
                StTag9: begin
                    if (pos_q == 2'd0 && byte_i == AsciiNine) begin
                        pos_d = 2'd1;
                    end else if (pos_q == 2'd1 && byte_i == AsciiEq) begin
                        state_d = StLen;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ErrNoTag9;
                        state_d = StIdle;
                    end
                end
                StLen: begin
                    if (byte_i == AsciiSoh) begin
                        if (len_nd == '0) begin
                            err_d   = 1'b1;
                            code_d  = ErrBadDigit;
                            state_d = StIdle;
                        end else begin
                            len_d   = len_acc;
                            pos_d   = 2'd0;
                            state_d = (len_acc == '0) ? StTrailer : StBody;
                        end
                    end else if (len_non_digit || len_nd == CntW'(MAX_DIGITS)) begin
                        err_d   = 1'b1;
                        code_d  = ErrBadDigit;
                        state_d = StIdle;
                    end else if (len_ovf) begin
                        err_d   = 1'b1;
                        code_d  = ErrOverflow;
                        state_d = StIdle;
                    end else begin
                        len_dv = 1'b1;
                    end
                end
                StBody: begin
                    cnt_d = cnt_inc;
                    // The byte completing the declared length must close the last body field.
                    if (cnt_inc == len_q) begin
                        if (byte_i == AsciiSoh) begin
                            state_d = StTrailer;
                            pos_d   = 2'd0;
                        end else begin
                            err_d   = 1'b1;
                            code_d  = ErrTrailer;
                            state_d = StIdle;
                        end
                    end
                end
                StTrailer: begin
                    if (byte_i != trl_exp) begin
                        err_d   = 1'b1;
                        code_d  = ErrTrailer;
                        state_d = StIdle;
                    end else if (pos_q != 2'd2) begin
                        pos_d = pos_q + 2'd1;
                    end else begin
`ifdef FIX_RX_CHECKSUM_EN
                        state_d = StCsum;
`else
                        done_d  = 1'b1;
                        state_d = StIdle;
`endif
                    end
                end
`ifdef FIX_RX_CHECKSUM_EN
                StCsum: begin
                    if (cs_nd == 2'd3) begin
                        if (byte_i == AsciiSoh && cs_acc == {2'b00, sum_q}) begin
                            done_d = 1'b1;
                        end else begin
                            err_d  = 1'b1;
                            code_d = ErrCsum;
                        end
                        state_d = StIdle;
                    end else if (cs_non_digit || cs_ovf) begin
                        err_d   = 1'b1;
                        code_d  = ErrCsum;
                        state_d = StIdle;
                    end else begin
                        cs_dv = 1'b1;
                    end
                end
`endif
                default: state_d = StIdle;
            endcase
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            pos_q   <= 2'd0;
            len_q   <= '0;
            cnt_q   <= '0;
            code_q  <= ErrNone;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

`ifdef FIX_RX_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end
    assign checksum_o = sum_q;
`else
    assign checksum_o = 8'h00;
`endif

    assign body_len_o = len_q;
    assign body_cnt_o = cnt_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_code_o = code_q;

endmodule

// File: tb/tb_fix_bodylength_rx.sv
// Self-checking bench for fix_bodylength_rx: directed frame table, corner-case sequences and
// randomized frames checked against a whole-frame parsing model.
module tb_fix_bodylength_rx;

    localparam int unsigned LW = 16;
    localparam int unsigned MD = 5;
    localparam logic [7:0] B_SOH = 8'h01;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  byte_i = 8'h00;
    logic        byte_valid_i = 1'b0;
    logic        sof_i = 1'b0;
    logic [LW-1:0] body_len_o, body_cnt_o;
    logic        busy_o, done_o, err_o;
    logic [2:0]  err_code_o;
    logic [7:0]  checksum_o;
    logic [7:0]  len8_o, cnt8_o, cs8_o;
    logic        busy8_o, done8_o, err8_o;
    logic [2:0]  code8_o;

    always #5 clk = ~clk;

    fix_bodylength_rx #(.LEN_WIDTH(LW), .MAX_DIGITS(MD)) dut (
        .clk(clk), .rst(rst), .byte_i(byte_i), .byte_valid_i(byte_valid_i), .sof_i(sof_i),
        .body_len_o(body_len_o), .body_cnt_o(body_cnt_o), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .err_code_o(err_code_o), .checksum_o(checksum_o)
    );

    fix_bodylength_rx #(.LEN_WIDTH(8), .MAX_DIGITS(MD)) dut8 (
        .clk(clk), .rst(rst), .byte_i(byte_i), .byte_valid_i(byte_valid_i), .sof_i(sof_i),
        .body_len_o(len8_o), .body_cnt_o(cnt8_o), .busy_o(busy8_o), .done_o(done8_o),
        .err_o(err8_o), .err_code_o(code8_o), .checksum_o(cs8_o)
    );

    typedef struct {
        int done; int err; int code; int len; int cnt; int dec; int busy; int cs;
    } exp_t;

    typedef struct {
        string txt;
        exp_t  e;
    } vec_t;

    int tests = 0;
    int fails = 0;
    logic [7:0] frame[$];
    int n_done, n_err, n_err8, dec_idx, last_idx;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) frame.push_back(s[i] == 8'h7c ? B_SOH : s[i]);
    endtask

    task automatic load(input string s);
        frame.delete();
        push_str(s);
    endtask

    task automatic step(input logic v, input logic [7:0] b, input logic s, input int idx);
        @(negedge clk);
        byte_valid_i = v;
        byte_i       = b;
        sof_i        = s;
        @(posedge clk);
        #1;
        if (v) last_idx = idx;
        if (done_o) begin n_done++; dec_idx = last_idx; end
        if (err_o) begin n_err++; dec_idx = last_idx; end
        if (err8_o) n_err8++;
        byte_valid_i = 1'b0;
        sof_i        = 1'b0;
    endtask

    // gap: 0 none, 1 idle cycle before every byte, 2 random idle cycles
    task automatic send_frame(input int gap);
        n_done = 0; n_err = 0; n_err8 = 0; dec_idx = -1; last_idx = -1;
        for (int i = 0; i < frame.size(); i++) begin
            if (gap == 1 || (gap == 2 && $urandom_range(0, 3) == 0)) step(1'b0, 8'h38, 1'b1, -1);
            step(1'b1, frame[i], i == 0, i);
        end
        repeat (3) step(1'b0, 8'h38, 1'b1, -1);
    endtask

    task automatic check_frame(input string tag, input exp_t e);
        check($sformatf("%s done_count", tag), n_done, e.done);
        check($sformatf("%s err_count", tag), n_err, e.err);
        check($sformatf("%s err_code", tag), int'(err_code_o), e.code);
        check($sformatf("%s body_len", tag), int'(body_len_o), e.len);
        check($sformatf("%s body_cnt", tag), int'(body_cnt_o), e.cnt);
        check($sformatf("%s busy", tag), int'(busy_o), e.busy);
        if (e.dec != -2) check($sformatf("%s decide_idx", tag), dec_idx, e.dec);
`ifdef FIX_RX_CHECKSUM_EN
        if (e.cs >= 0) check($sformatf("%s checksum", tag), int'(checksum_o), e.cs);
`else
        check($sformatf("%s checksum", tag), int'(checksum_o), 0);
`endif
    endtask

    function automatic exp_t reject(input exp_t e0, input int code, input int at, input int sum);
        exp_t e = e0;
        e.err = 1; e.code = code; e.dec = at; e.busy = 0; e.cs = sum % 256;
        return e;
    endfunction

    function automatic exp_t open_end(input exp_t e0, input int sum);
        exp_t e = e0;
        e.cs = sum % 256;
        return e;
    endfunction

    function automatic logic dig(input logic [7:0] b);
        return b >= 8'h30 && b <= 8'h39;
    endfunction

    // Parses the whole frame from the text rules and predicts the final outcome.
    function automatic exp_t predict();
        exp_t e;
        int n, i, nd, sum;
        longint val;
        logic [7:0] want;
        n = frame.size();
        e = '{default: 0};
        e.dec = -1; e.busy = 1;
        sum = int'(frame[0]);
        i = 1;
        while (i < n && frame[i] != B_SOH) begin sum += int'(frame[i]); i++; end
        if (i >= n) return open_end(e, sum);
        sum += 1; i++;
        for (int k = 0; k < 2; k++) begin
            if (i >= n) return open_end(e, sum);
            sum += int'(frame[i]);
            want = (k == 0) ? 8'h39 : 8'h3d;
            if (frame[i] != want) return reject(e, 1, i, sum);
            i++;
        end
        val = 0; nd = 0;
        while (1) begin
            if (i >= n) return open_end(e, sum);
            sum += int'(frame[i]);
            if (frame[i] == B_SOH) begin
                if (nd == 0) return reject(e, 2, i, sum);
                i++;
                break;
            end
            if (!dig(frame[i]) || nd == MD) return reject(e, 2, i, sum);
            val = val * 10 + longint'(frame[i] - 8'h30);
            if (val > (longint'(1) << LW) - 1) return reject(e, 5, i, sum);
            nd++; i++;
        end
        e.len = int'(val);
        while (e.cnt < e.len) begin
            if (i >= n) return open_end(e, sum);
            sum += int'(frame[i]);
            e.cnt++;
            if (e.cnt == e.len && frame[i] != B_SOH) return reject(e, 3, i, sum);
            i++;
        end
        for (int k = 0; k < 3; k++) begin
            if (i >= n) return open_end(e, sum);
            want = (k == 0) ? 8'h31 : (k == 1) ? 8'h30 : 8'h3d;
            if (frame[i] != want) return reject(e, 3, i, sum);
            i++;
        end
`ifdef FIX_RX_CHECKSUM_EN
        val = 0;
        for (int k = 0; k < 3; k++) begin
            if (i >= n) return open_end(e, sum);
            if (!dig(frame[i])) return reject(e, 4, i, sum);
            val = val * 10 + longint'(frame[i] - 8'h30);
            i++;
        end
        if (i >= n) return open_end(e, sum);
        if (frame[i] != B_SOH || val != longint'(sum % 256)) return reject(e, 4, i, sum);
        e.done = 1; e.dec = i; e.busy = 0; e.cs = sum % 256;
`else
        e.done = 1; e.dec = i - 1; e.busy = 0; e.cs = sum % 256;
`endif
        return e;
    endfunction

    task automatic gen_frame();
        int r, len, alen, sum;
        string ds;
        frame.delete();
        push_str("8=FIX.4.2|");
        r = $urandom_range(0, 9);
        push_str(r == 0 ? "7=" : "9=");
        len = $urandom_range(0, 30);
        if (r == 1) ds = $sformatf("%0d", $urandom_range(65536, 99999));
        else if (r == 2) ds = $sformatf("%06d", len);
        else if (r == 7) ds = "";
        else ds = $sformatf("%0d", len);
        if (r == 3) ds = {ds.substr(0, 0), "x", ds.substr(1, ds.len() - 1)};
        push_str({ds, "|"});
        alen = len;
        if (r == 4) alen = len + 1;
        if (r == 5 && len > 0) alen = len - 1;
        for (int j = 0; j < alen; j++)
            frame.push_back(j == alen - 1 ? B_SOH : 8'($urandom_range(32, 126)));
        sum = 0;
        foreach (frame[j]) sum += int'(frame[j]);
        push_str(r == 6 ? "1X=" : "10=");
        push_str($sformatf("%03d|", (r == 8) ? (sum + 1) % 256 : sum % 256));
    endtask

    vec_t tbl[$];
    exp_t ex;

    initial begin
        tbl.push_back('{"8=FIX.4.2|9=5|35=0|10=161|",      '{1, 0, 0, 5, 5, -2, 0, 161}});
        tbl.push_back('{"8=FIX.4.2|9=6|35=0|10=161|",      '{0, 1, 3, 6, 6, -2, 0, -1}});
        tbl.push_back('{"8=FIX.4.2|35=0|10=161|",          '{0, 1, 1, 0, 0, -2, 0, -1}});
        tbl.push_back('{"8=FIX.4.2|9=12a|",                '{0, 1, 2, 0, 0, -2, 0, -1}});
        tbl.push_back('{"8=FIX.4.2|9=123456|",             '{0, 1, 2, 0, 0, -2, 0, -1}});
        tbl.push_back('{"8=FIX.4.2|9=|",                   '{0, 1, 2, 0, 0, -2, 0, -1}});
        tbl.push_back('{"8=FIX.4.2|9=65536|",              '{0, 1, 5, 0, 0, -2, 0, -1}});
        tbl.push_back('{"8=FIX.4.2|9=65535|",              '{0, 0, 0, 65535, 0, -2, 1, -1}});
        tbl.push_back('{"8=FIX.4.2|9=0|10=198|",           '{1, 0, 0, 0, 0, -2, 0, 198}});
        tbl.push_back('{"8=FIX.4.2|9=00005|35=0|10=097|",  '{1, 0, 0, 5, 5, -2, 0, 97}});
        tbl.push_back('{"8=FIX.4.2|9=5|35=0|11=161|",      '{0, 1, 3, 5, 5, -2, 0, 161}});
        tbl.push_back('{"8=FIX.4.2|9=5|35=01|10=161|",     '{0, 1, 3, 5, 5, -2, 0, -1}});
`ifdef FIX_RX_CHECKSUM_EN
        tbl.push_back('{"8=FIX.4.2|9=5|35=0|10=160|",      '{0, 1, 4, 5, 5, -2, 0, 161}});
`else
        tbl.push_back('{"8=FIX.4.2|9=5|35=0|10=160|",      '{1, 0, 0, 5, 5, -2, 0, -1}});
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset body_len", int'(body_len_o), 0);
        check("reset body_cnt", int'(body_cnt_o), 0);
        check("reset busy", int'(busy_o), 0);
        check("reset done", int'(done_o), 0);
        check("reset err", int'(err_o), 0);
        check("reset err_code", int'(err_code_o), 0);
        check("reset checksum", int'(checksum_o), 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[k]) begin
            load(tbl[k].txt);
            send_frame(0);
            check_frame($sformatf("vec%0d", k), tbl[k].e);
        end

        // Valid toggled every other cycle must give identical results
        load(tbl[0].txt);
        send_frame(1);
        check_frame("gapped", tbl[0].e);

        // sof mid-BODY aborts silently, then the new frame parses normally
        load("8=FIX.4.2|9=5|35");
        send_frame(0);
        check("midbody busy", int'(busy_o), 1);
        check("midbody body_cnt", int'(body_cnt_o), 2);
        check("midbody err_count", n_err, 0);
        load(tbl[0].txt);
        send_frame(0);
        check_frame("after_abort", tbl[0].e);

        // Narrow length field overflows on 300
        load("8=FIX.4.2|9=300|");
        send_frame(0);
        check("w8 err_count", n_err8, 1);
        check("w8 err_code", int'(code8_o), 5);
        check("w16 body_len", int'(body_len_o), 300);

        // Reset mid-LEN clears everything with no pulse
        load("8=FIX.4.2|9=12");
        send_frame(0);
        check("midlen busy", int'(busy_o), 1);
        @(negedge clk);
        rst = 1'b0;
        byte_valid_i = 1'b1;
        byte_i = 8'h33;
        @(posedge clk);
        #1;
        check("rst body_len", int'(body_len_o), 0);
        check("rst body_cnt", int'(body_cnt_o), 0);
        check("rst busy", int'(busy_o), 0);
        check("rst done", int'(done_o), 0);
        check("rst err", int'(err_o), 0);
        check("rst err_code", int'(err_code_o), 0);
        check("rst checksum", int'(checksum_o), 0);
        @(negedge clk);
        rst = 1'b1;
        byte_valid_i = 1'b0;

        for (int k = 0; k < 200; k++) begin
            gen_frame();
            ex = predict();
            send_frame(int'($urandom_range(0, 2)));
            check_frame($sformatf("rand%0d", k), ex);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
